// File: rtl/alu_result_pkg.sv
// alu_result_pkg: opcode encodings shared by the ALU core and the result buffer.
package alu_result_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational 8-op ALU with carry/borrow/shifted-out bit.
module alu_core
    import alu_result_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] res,
    output logic             carry
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    always_comb begin
        res   = '0;
        carry = 1'b0;
        case (sel)
            OP_ADD: begin res = sum[WIDTH-1:0];  carry = sum[WIDTH];  end
            OP_SUB: begin res = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_SHL: begin res = a << 1; carry = a[WIDTH-1]; end
            default: begin res = a >> 1; carry = a[0]; end
        endcase
    end
endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: ALU whose results are queued in a FIFO and popped into registered outputs.
// Define ALU_RESULT_BUFFER_CARRY_EN to store a carry bit per entry and expose carryFlag.
module alu_result_buffer
    import alu_result_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             en,
    input  logic             rd,
    output logic [WIDTH-1:0] dataOut,
    output logic             valid,
    output logic             zeroFlag,
`ifdef ALU_RESULT_BUFFER_CARRY_EN
    output logic             carryFlag,
`endif
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d, zero_q, zero_d, ovf_q, ovf_d;
    logic             wr, pop;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a    (a),
        .b    (b),
        .sel  (sel),
        .res  (alu_res),
        .carry(alu_carry)
    );

    assign full  = count_q == FULL_CNT;
    assign empty = count_q == '0;
    assign wr    = en && !full;
    // en wins over rd, so a pop only happens on a cycle with no write request
    assign pop   = !en && rd && !empty;

    always_comb begin
        wr_ptr_d   = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = wr ? count_q + 1'b1 : pop ? count_q - 1'b1 : count_q;
        data_out_d = pop ? mem[rd_ptr_q] : data_out_q;
        zero_d     = pop ? mem[rd_ptr_q] == '0 : zero_q;
        valid_d    = pop;
        ovf_d      = ovf_q || (en && full);
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q] <= alu_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef ALU_RESULT_BUFFER_CARRY_EN
    logic carry_mem [DEPTH];
    logic carry_q, carry_d;
    assign carry_d = pop ? carry_mem[rd_ptr_q] : carry_q;
    always_ff @(posedge clk) begin
        if (wr) carry_mem[wr_ptr_q] <= alu_carry;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) carry_q <= 1'b0;
        else        carry_q <= carry_d;
    end
    assign carryFlag = carry_q;
`else
    logic alu_carry_unused;
    assign alu_carry_unused = alu_carry;
`endif

    assign dataOut  = data_out_q;
    assign valid    = valid_q;
    assign zeroFlag = zero_q;
    assign count    = count_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed self-checking bench for alu_result_buffer (DEPTH=4).
module tb_alu_result_buffer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [2:0] sel = '0;
    logic       en = 1'b0, rd = 1'b0;
    logic [7:0] dataOut;
    logic       valid, zeroFlag, full, empty, overflow;
    logic [2:0] count;
`ifdef ALU_RESULT_BUFFER_CARRY_EN
    logic       carryFlag;
`endif
    int checks = 0;
    int errors = 0;

    alu_result_buffer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .sel      (sel),
        .en       (en),
        .rd       (rd),
        .dataOut  (dataOut),
        .valid    (valid),
        .zeroFlag (zeroFlag),
`ifdef ALU_RESULT_BUFFER_CARRY_EN
        .carryFlag(carryFlag),
`endif
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic r, input logic [7:0] av,
                        input logic [7:0] bv, input logic [2:0] s);
        @(negedge clk);
        en = e; rd = r; a = av; b = bv; sel = s;
        @(posedge clk);
        #1;
        en = 1'b0; rd = 1'b0;
    endtask

    task automatic wr(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] s);
        step(1'b1, 1'b0, av, bv, s);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d, input logic z, input logic c);
        step(1'b0, 1'b1, 8'd0, 8'd0, 3'd0);
        check({tag, "_valid"}, valid, 1'b1);
        check({tag, "_data"}, dataOut, d);
        check({tag, "_zero"}, zeroFlag, z);
`ifdef ALU_RESULT_BUFFER_CARRY_EN
        check({tag, "_carry"}, carryFlag, c);
`else
        if (c === 1'bx) check({tag, "_carry_x"}, c, 1'b0);
`endif
    endtask

    task automatic status(input string tag, input logic [2:0] cnt, input logic f,
                          input logic e, input logic o);
        check({tag, "_count"}, count, cnt);
        check({tag, "_full"}, full, f);
        check({tag, "_empty"}, empty, e);
        check({tag, "_ovf"}, overflow, o);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        status("rst", 3'd0, 1'b0, 1'b1, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_data", dataOut, 8'd0);
        check("rst_zero", zeroFlag, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        wr(8'd70, 8'd4, 3'b000);
        wr(8'd100, 8'd11, 3'b000);
        wr(8'd100, 8'd15, 3'b000);
        status("add3", 3'd3, 1'b0, 1'b0, 1'b0);
        pop_chk("pop74", 8'd74, 1'b0, 1'b0);
        pop_chk("pop111", 8'd111, 1'b0, 1'b0);
        pop_chk("pop115", 8'd115, 1'b0, 1'b0);
        status("drained", 3'd0, 1'b0, 1'b1, 1'b0);

        step(1'b0, 1'b1, 8'd0, 8'd0, 3'd0);
        check("empty_pop_valid", valid, 1'b0);
        check("empty_pop_data", dataOut, 8'd115);
        step(1'b0, 1'b0, 8'd0, 8'd0, 3'd0);
        check("idle_valid", valid, 1'b0);

        wr(8'd5, 8'd5, 3'b001);
        pop_chk("sub_zero", 8'd0, 1'b1, 1'b0);
        wr(8'd3, 8'd5, 3'b001);
        pop_chk("sub_borrow", 8'd254, 1'b0, 1'b1);

        wr(8'h0F, 8'hF0, 3'b100);
        step(1'b1, 1'b1, 8'hCC, 8'hAA, 3'b010);
        check("enrd_valid", valid, 1'b0);
        check("enrd_data", dataOut, 8'd254);
        status("enrd", 3'd2, 1'b0, 1'b0, 1'b0);
        pop_chk("xor", 8'hFF, 1'b0, 1'b0);
        pop_chk("and", 8'h88, 1'b0, 1'b0);

        wr(8'd1, 8'd2, 3'b011);
        wr(8'h0F, 8'd0, 3'b101);
        wr(8'h81, 8'd0, 3'b110);
        status("third", 3'd3, 1'b0, 1'b0, 1'b0);
        wr(8'h81, 8'd0, 3'b111);
        status("fourth", 3'd4, 1'b1, 1'b0, 1'b0);
        wr(8'd1, 8'd1, 3'b000);
        status("fifth", 3'd4, 1'b1, 1'b0, 1'b1);
        pop_chk("or", 8'd3, 1'b0, 1'b0);
        pop_chk("not", 8'hF0, 1'b0, 1'b0);
        pop_chk("shl", 8'h02, 1'b0, 1'b1);
        pop_chk("shr", 8'h40, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'd0, 8'd0, 3'd0);
        check("after_full_valid", valid, 1'b0);
        status("after_full", 3'd0, 1'b0, 1'b1, 1'b1);

        wr(8'd200, 8'd1, 3'b001);
        wr(8'd200, 8'd100, 3'b000);
        wr(8'h55, 8'h55, 3'b100);
        pop_chk("wrap0", 8'd199, 1'b0, 1'b0);
        pop_chk("wrap1", 8'd44, 1'b0, 1'b1);
        pop_chk("wrap2", 8'd0, 1'b1, 1'b0);

        wr(8'd9, 8'd1, 3'b000);
        wr(8'd20, 8'd2, 3'b000);
        status("pre_arst", 3'd2, 1'b0, 1'b0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        status("arst", 3'd0, 1'b0, 1'b1, 1'b0);
        check("arst_zero", zeroFlag, 1'b0);
        check("arst_data", dataOut, 8'd0);
        check("arst_valid", valid, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        wr(8'd7, 8'd8, 3'b000);
        pop_chk("post_rst", 8'd15, 1'b0, 1'b0);
        status("post_rst", 3'd0, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
